// File: rtl/exmem_stage_task3.sv
`default_nettype none
// ============================================================================
// Module   : exmem_stage_task3
// Brief    : EX stage plus EX/MEM pipeline register of the 5-stage RV64 core.
//            Forwards operands from EX/MEM and MEM/WB, decodes and executes
//            the ALU op, computes branch target and condition, and latches
//            everything into EX/MEM. pc_src steers fetch and squashes the
//            younger instructions.
// Config   : BRANCH_EXT_EN - full RV branch compare set (BNE/BLT/BGE/BLTU/
//            BGEU). When undefined every branch behaves as BEQ.
// Revision : 1.0 - initial release
// ============================================================================
module exmem_stage_task3 #(
    parameter int XLEN = 64,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] readdata1,
    input  logic [XLEN-1:0] readdata2,
    input  logic [XLEN-1:0] imm_data,
    input  logic [RW-1:0]   rs1,
    input  logic [RW-1:0]   rs2,
    input  logic [RW-1:0]   rd,
    input  logic [3:0]      funct4,
    input  logic            Branch,
    input  logic            Memread,
    input  logic            Memtoreg,
    input  logic            Memwrite,
    input  logic            Regwrite,
    input  logic            Alusrc,
    input  logic [1:0]      aluop,
    input  logic            hold,
    input  logic            flush,
    input  logic [RW-1:0]   memwb_rd,
    input  logic            memwb_regwrite,
    input  logic [XLEN-1:0] memwb_wdata,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] write_data,
    output logic            zero,
    output logic [RW-1:0]   rd_out,
    output logic            Branch_o,
    output logic            Memread_o,
    output logic            Memtoreg_o,
    output logic            Memwrite_o,
    output logic            Regwrite_o,
    output logic            pc_src
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_sel_e;

    // EX/MEM register state
    logic [XLEN-1:0] bt_q,  bt_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] wd_q,  wd_d;
    logic            zero_q, zero_d;
    logic [RW-1:0]   rd_q,  rd_d;
    logic            br_q,  br_d;
    logic            mr_q,  mr_d;
    logic            mtr_q, mtr_d;
    logic            mw_q,  mw_d;
    logic            rw_q,  rw_d;
    logic            taken_q, taken_d;

    // EX-stage combinational values
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    alu_sel_e        alu_sel;
    logic            taken;

    // Operand forwarding; the younger EX/MEM result wins over MEM/WB, x0 never forwards
    always_comb begin
        fwd_a = readdata1;
        if (rw_q && (rd_q != '0) && (rd_q == rs1)) begin
            fwd_a = alu_q;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs1)) begin
            fwd_a = memwb_wdata;
        end

        fwd_b = readdata2;
        if (rw_q && (rd_q != '0) && (rd_q == rs2)) begin
            fwd_b = alu_q;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs2)) begin
            fwd_b = memwb_wdata;
        end

        op_b  = Alusrc ? imm_data : fwd_b;
        shamt = op_b[SHW-1:0];
    end

    // ALU control decode; anything unrecognised falls back to ADD
    always_comb begin
        alu_sel = ALU_ADD;
        case (aluop)
            2'b00: alu_sel = ALU_ADD;
            2'b01: alu_sel = ALU_SUB;
            2'b10: begin
                case (funct4)
                    4'b0000: alu_sel = ALU_ADD;
                    4'b1000: alu_sel = ALU_SUB;
                    4'b0111: alu_sel = ALU_AND;
                    4'b0110: alu_sel = ALU_OR;
                    4'b0100: alu_sel = ALU_XOR;
                    4'b0001: alu_sel = ALU_SLL;
                    4'b0101: alu_sel = ALU_SRL;
                    4'b1101: alu_sel = ALU_SRA;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

    // ALU datapath; arithmetic wraps, shift amount is the low bits of operand B
    always_comb begin
        alu_res = fwd_a + op_b;
        case (alu_sel)
            ALU_ADD: alu_res = fwd_a + op_b;
            ALU_SUB: alu_res = fwd_a - op_b;
            ALU_AND: alu_res = fwd_a & op_b;
            ALU_OR:  alu_res = fwd_a | op_b;
            ALU_XOR: alu_res = fwd_a ^ op_b;
            ALU_SLL: alu_res = fwd_a << shamt;
            ALU_SRL: alu_res = fwd_a >> shamt;
            ALU_SRA: alu_res = $unsigned($signed(fwd_a) >>> shamt);
            default: alu_res = fwd_a + op_b;
        endcase
    end

`ifdef BRANCH_EXT_EN
    // Branch condition selected by funct3 on the forwarded register operands
    always_comb begin
        taken = 1'b0;
        case (funct4[2:0])
            3'b000:  taken = (fwd_a == fwd_b);
            3'b001:  taken = (fwd_a != fwd_b);
            3'b100:  taken = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  taken = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  taken = (fwd_a <  fwd_b);
            3'b111:  taken = (fwd_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end
`else
    // Every branch is treated as BEQ: taken when the subtract result is zero
    always_comb begin
        taken = (alu_res == '0);
    end
`endif

    // EX/MEM next state: flush kills control but lets data load, hold freezes everything
    always_comb begin
        bt_d    = bt_q;
        alu_d   = alu_q;
        wd_d    = wd_q;
        zero_d  = zero_q;
        rd_d    = rd_q;
        br_d    = br_q;
        mr_d    = mr_q;
        mtr_d   = mtr_q;
        mw_d    = mw_q;
        rw_d    = rw_q;
        taken_d = taken_q;
        if (flush || !hold) begin
            bt_d   = a + (imm_data << 1);
            alu_d  = alu_res;
            wd_d   = fwd_b;
            zero_d = (alu_res == '0);
            rd_d   = rd;
        end
        if (flush) begin
            br_d    = 1'b0;
            mr_d    = 1'b0;
            mtr_d   = 1'b0;
            mw_d    = 1'b0;
            rw_d    = 1'b0;
            taken_d = 1'b0;
        end else if (!hold) begin
            br_d    = Branch;
            mr_d    = Memread;
            mtr_d   = Memtoreg;
            mw_d    = Memwrite;
            rw_d    = Regwrite;
            taken_d = taken;
        end
    end

    // EX/MEM register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bt_q    <= '0;
            alu_q   <= '0;
            wd_q    <= '0;
            zero_q  <= 1'b0;
            rd_q    <= '0;
            br_q    <= 1'b0;
            mr_q    <= 1'b0;
            mtr_q   <= 1'b0;
            mw_q    <= 1'b0;
            rw_q    <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            bt_q    <= bt_d;
            alu_q   <= alu_d;
            wd_q    <= wd_d;
            zero_q  <= zero_d;
            rd_q    <= rd_d;
            br_q    <= br_d;
            mr_q    <= mr_d;
            mtr_q   <= mtr_d;
            mw_q    <= mw_d;
            rw_q    <= rw_d;
            taken_q <= taken_d;
        end
    end

    assign branch_target = bt_q;
    assign alu_result    = alu_q;
    assign write_data    = wd_q;
    assign zero          = zero_q;
    assign rd_out        = rd_q;
    assign Branch_o      = br_q;
    assign Memread_o     = mr_q;
    assign Memtoreg_o    = mtr_q;
    assign Memwrite_o    = mw_q;
    assign Regwrite_o    = rw_q;
    assign pc_src        = br_q & taken_q;

endmodule
`default_nettype wire

// File: tb/tb_exmem_stage_task3.sv
`default_nettype none
// ============================================================================
// Module   : tb_exmem_stage_task3
// Brief    : Directed bench for exmem_stage_task3 with a reference model of
//            the EX/MEM register compared every cycle, plus literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exmem_stage_task3;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a, readdata1, readdata2, imm_data, memwb_wdata;
    logic [4:0]  rs1, rs2, rd, memwb_rd;
    logic [3:0]  funct4;
    logic        Branch, Memread, Memtoreg, Memwrite, Regwrite, Alusrc;
    logic [1:0]  aluop;
    logic        hold, flush, memwb_regwrite;
    logic [63:0] branch_target, alu_result, write_data;
    logic        zero;
    logic [4:0]  rd_out;
    logic        Branch_o, Memread_o, Memtoreg_o, Memwrite_o, Regwrite_o, pc_src;

    int n_chk  = 0;
    int n_fail = 0;

    exmem_stage_task3 dut (
        .clk(clk), .reset(reset), .a(a), .readdata1(readdata1), .readdata2(readdata2),
        .imm_data(imm_data), .rs1(rs1), .rs2(rs2), .rd(rd), .funct4(funct4),
        .Branch(Branch), .Memread(Memread), .Memtoreg(Memtoreg), .Memwrite(Memwrite),
        .Regwrite(Regwrite), .Alusrc(Alusrc), .aluop(aluop), .hold(hold), .flush(flush),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_wdata(memwb_wdata),
        .branch_target(branch_target), .alu_result(alu_result), .write_data(write_data),
        .zero(zero), .rd_out(rd_out), .Branch_o(Branch_o), .Memread_o(Memread_o),
        .Memtoreg_o(Memtoreg_o), .Memwrite_o(Memwrite_o), .Regwrite_o(Regwrite_o),
        .pc_src(pc_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_bt, m_alu, m_wd;
    logic        m_zero, m_br, m_mr, m_mtr, m_mw, m_rw, m_tk;
    logic [4:0]  m_rd;
    logic [63:0] m_fa, m_fb, m_res;

    function automatic logic [63:0] fwd(input logic [4:0] r, input logic [63:0] regval);
        if (r != 0 && m_rw && m_rd == r)                 return m_alu;
        if (r != 0 && memwb_regwrite && memwb_rd == r)   return memwb_wdata;
        return regval;
    endfunction

    function automatic logic [63:0] alu_f(input logic [1:0] op, input logic [3:0] f,
                                          input logic [63:0] x, input logic [63:0] y);
        int sh;
        sh = int'(y[5:0]);
        if (op == 2'b01) return x - y;
        if (op != 2'b10) return x + y;
        case (f)
            4'b1000: return x - y;
            4'b0111: return x & y;
            4'b0110: return x | y;
            4'b0100: return x ^ y;
            4'b0001: return x << sh;
            4'b0101: return x >> sh;
            4'b1101: return $unsigned($signed(x) >>> sh);
            default: return x + y;
        endcase
    endfunction

    function automatic logic taken_f(input logic [3:0] f, input logic [63:0] x,
                                     input logic [63:0] y, input logic [63:0] r);
`ifdef BRANCH_EXT_EN
        case (f[2:0])
            3'b000: return x == y;
            3'b001: return x != y;
            3'b100: return $signed(x) <  $signed(y);
            3'b101: return $signed(x) >= $signed(y);
            3'b110: return x < y;
            3'b111: return x >= y;
            default: return 1'b0;
        endcase
`else
        return (r == 64'd0) || (f != f) || (x != x) || (y != y);
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_bt = 0; m_alu = 0; m_wd = 0; m_zero = 0; m_rd = 0;
            m_br = 0; m_mr = 0; m_mtr = 0; m_mw = 0; m_rw = 0; m_tk = 0;
        end else if (flush || !hold) begin
            m_fa  = fwd(rs1, readdata1);
            m_fb  = fwd(rs2, readdata2);
            m_res = alu_f(aluop, funct4, m_fa, Alusrc ? imm_data : m_fb);
            m_tk  = flush ? 1'b0 : taken_f(funct4, m_fa, m_fb, m_res);
            m_bt  = a + imm_data * 2;
            m_alu = m_res;
            m_wd  = m_fb;
            m_zero = (m_res == 0);
            m_rd  = rd;
            m_br  = Branch   & ~flush;
            m_mr  = Memread  & ~flush;
            m_mtr = Memtoreg & ~flush;
            m_mw  = Memwrite & ~flush;
            m_rw  = Regwrite & ~flush;
        end
    end

    // every-cycle comparison against the model
    always @(posedge clk) begin
        #2;
        chk("m_bt",   branch_target, m_bt);
        chk("m_alu",  alu_result,    m_alu);
        chk("m_wd",   write_data,    m_wd);
        chk("m_zero", 64'(zero),     64'(m_zero));
        chk("m_rd",   64'(rd_out),   64'(m_rd));
        chk("m_ctl",  {59'd0, Branch_o, Memread_o, Memtoreg_o, Memwrite_o, Regwrite_o},
                      {59'd0, m_br, m_mr, m_mtr, m_mw, m_rw});
        chk("m_pcsrc", 64'(pc_src),  64'(m_br & m_tk));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr();
        a = 0; readdata1 = 0; readdata2 = 0; imm_data = 0; memwb_wdata = 0;
        rs1 = 0; rs2 = 0; rd = 0; memwb_rd = 0; funct4 = 0; aluop = 0;
        Branch = 0; Memread = 0; Memtoreg = 0; Memwrite = 0; Regwrite = 0; Alusrc = 0;
        hold = 0; flush = 0; memwb_regwrite = 0;
    endtask

    task automatic beq_taken();
        clr(); a = 64'h100; imm_data = 8; readdata1 = 4; readdata2 = 4;
        Branch = 1; aluop = 2'b01; funct4 = 4'b0000;
    endtask

    logic [3:0]  f4_tab [0:8] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                                   4'b0001, 4'b0101, 4'b1101, 4'b0011};
    logic [3:0]  bf_tab [0:5] = '{4'b0001, 4'b0100, 4'b0110, 4'b0101, 4'b0111, 4'b0100};
    logic [63:0] b1_tab [0:5] = '{64'd4, -64'sd1, -64'sd1, 64'd1, 64'd2, 64'd3};
    logic [63:0] b2_tab [0:5] = '{64'd5, 64'd1, 64'd1, -64'sd1, 64'd2, 64'd3};

    initial begin
        reset = 1; clr();
        tick(); tick();
        chk("rst_alu", alu_result, 64'd0);
        chk("rst_bt", branch_target, 64'd0);
        chk("rst_ctl", {Regwrite_o, Branch_o, pc_src}, 64'd0);
        reset = 0;

        // ADD x3 = 5 + 7
        clr(); aluop = 2'b10; readdata1 = 5; readdata2 = 7; rs1 = 1; rs2 = 2; rd = 3; Regwrite = 1;
        tick();
        chk("add_res", alu_result, 64'd12);
        chk("add_zero", 64'(zero), 64'd0);
        chk("add_rd", 64'(rd_out), 64'd3);
        chk("add_rw", 64'(Regwrite_o), 64'd1);

        // double hit: EX/MEM (12) beats MEM/WB (50)
        clr(); rs1 = 3; readdata1 = 99; readdata2 = 1; rd = 4; Regwrite = 1;
        memwb_rd = 3; memwb_regwrite = 1; memwb_wdata = 50;
        tick();
        chk("fwd_exmem", alu_result, 64'd13);

        // only MEM/WB hits now
        clr(); rs1 = 3; readdata1 = 99; rd = 0; Regwrite = 1;
        memwb_rd = 3; memwb_regwrite = 1; memwb_wdata = 50;
        tick();
        chk("fwd_memwb", alu_result, 64'd50);

        // x0 never forwards, even with rd_out==0 and memwb_rd==0 writing
        clr(); rs1 = 0; readdata1 = 8; memwb_rd = 0; memwb_regwrite = 1; memwb_wdata = 50;
        tick();
        chk("fwd_x0", alu_result, 64'd8);

        // store data takes forwarded rs2, address uses the immediate
        clr(); aluop = 2'b10; readdata1 = 64'h1234; rd = 6; Regwrite = 1;
        tick();
        clr(); Memwrite = 1; Alusrc = 1; imm_data = 16; rs1 = 1; readdata1 = 64'h1000;
        rs2 = 6; readdata2 = 0;
        tick();
        chk("st_addr", alu_result, 64'h1010);
        chk("st_data", write_data, 64'h1234);

        // ALU function table, shift amount uses B[5:0] (0x44 -> 4)
        for (int i = 0; i < 9; i++) begin
            clr(); aluop = 2'b10; funct4 = f4_tab[i]; rd = 7; Regwrite = 1;
            readdata1 = 64'hF0F0_0000_0000_00F3; readdata2 = 64'h44;
            tick();
            if (i == 7) chk("sra_lit", alu_result, 64'hFF0F_0000_0000_000F);
            if (i == 1) chk("sub_lit", alu_result, 64'hF0F0_0000_0000_00AF);
        end
        clr(); aluop = 2'b11; funct4 = 4'b1000; readdata1 = 3; readdata2 = 4;
        tick();
        chk("aluop11_add", alu_result, 64'd7);

        // BEQ taken, then fed-back flush squashes the next instruction
        beq_taken();
        tick();
        chk("beq_bt", branch_target, 64'h110);
        chk("beq_zero", 64'(zero), 64'd1);
        chk("beq_pcsrc", 64'(pc_src), 64'd1);
        clr(); flush = 1; Regwrite = 1; rd = 9; readdata1 = 1;
        tick();
        chk("beq_pcsrc_drop", 64'(pc_src), 64'd0);
        chk("flush_rw", 64'(Regwrite_o), 64'd0);

        // branch variants (condition set depends on configuration)
        for (int i = 0; i < 6; i++) begin
            clr(); Branch = 1; aluop = 2'b01; funct4 = bf_tab[i];
            readdata1 = b1_tab[i]; readdata2 = b2_tab[i]; a = 64'h200; imm_data = 64'(i);
            tick();
`ifdef BRANCH_EXT_EN
            if (i == 1) chk("blt_taken", 64'(pc_src), 64'd1);
            if (i == 2) chk("bltu_not", 64'(pc_src), 64'd0);
`else
            if (i == 1) chk("blt_as_beq", 64'(pc_src), 64'd0);
            if (i == 5) chk("f4_ignored", 64'(pc_src), 64'd1);
`endif
            clr(); flush = pc_src;
            tick();
        end

        // hold for 3 cycles with changing inputs
        clr(); aluop = 2'b10; readdata1 = 1; readdata2 = 2; rd = 10; Regwrite = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            clr(); hold = 1; readdata1 = 64'(i * 11 + 5); rd = 5'(i + 20);
            Regwrite = i[0]; Memwrite = 1;
            tick();
            chk("hold_alu", alu_result, 64'd3);
            chk("hold_rd", 64'(rd_out), 64'd10);
        end
        // held rd_out still forwards
        clr(); rs1 = 10; readdata1 = 0; rd = 11;
        tick();
        chk("fwd_after_hold", alu_result, 64'd3);

        // held taken branch, then flush beats hold
        beq_taken();
        tick();
        clr(); hold = 1;
        tick();
        chk("hold_pcsrc", 64'(pc_src), 64'd1);
        clr(); hold = 1; flush = 1; Regwrite = 1; rd = 12;
        tick();
        chk("flushhold_rw", 64'(Regwrite_o), 64'd0);
        chk("flushhold_pc", 64'(pc_src), 64'd0);

        // asynchronous reset mid-cycle clears outputs before the next edge
        beq_taken(); Regwrite = 1; rd = 13;
        tick();
        chk("pre_rst_pc", 64'(pc_src), 64'd1);
        #2 reset = 1;
        #1;
        chk("arst_pc", 64'(pc_src), 64'd0);
        chk("arst_bt", branch_target, 64'd0);
        chk("arst_ctl", {Branch_o, Regwrite_o, 3'(rd_out)}, 64'd0);
        tick();
        reset = 0; clr();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
